// File: rtl/add16_arbiter.sv
// add16_arbiter: round-robin arbiter sharing a single 16-bit adder between
// two requesters (A and B), with at most one operation in flight.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   a_valid/a_ready, a_x/a_y    requester A operand handshake and operands
//   a_rsp_valid/a_rsp_ready     requester A result handshake
//   b_*                         same set for requester B
//   sum                         registered result, qualified by *_rsp_valid
//   busy                        high while an operation is in EXEC or RESP

// Plain 16-bit wraparound adder; carry is intentionally dropped.
module add16 (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    output logic [15:0] sum_o
);
    assign sum_o = x_i + y_i;
endmodule

module add16_arbiter (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        a_valid,
    output logic        a_ready,
    input  logic [15:0] a_x,
    input  logic [15:0] a_y,
    output logic        a_rsp_valid,
    input  logic        a_rsp_ready,

    input  logic        b_valid,
    output logic        b_ready,
    input  logic [15:0] b_x,
    input  logic [15:0] b_y,
    output logic        b_rsp_valid,
    input  logic        b_rsp_ready,

    output logic [15:0] sum,
    output logic        busy
);

    localparam int unsigned W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Owner / last_grant encoding: 0 = A, 1 = B.
    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    state_t         state_q;
    logic           owner_q;
    logic           last_grant_q;
    logic [W-1:0]   x_q;
    logic [W-1:0]   y_q;
    logic [W-1:0]   sum_q;
    logic           a_rsp_valid_q;
    logic           b_rsp_valid_q;
    logic           busy_q;

    logic           grant_a;
    logic           grant_b;
    logic           owner_done;
    logic [W-1:0]   add_sum;

    add16 u_add16 (
        .x_i   (x_q),
        .y_i   (y_q),
        .sum_o (add_sum)
    );

    // Round-robin grant: a lone requester wins; on a tie the one that was
    // not granted last time wins.
    always_comb begin
        grant_a = a_valid && (!b_valid || (last_grant_q == OWN_B));
        grant_b = b_valid && (!a_valid || (last_grant_q == OWN_A));
    end

    // Ready is combinational so a request can be accepted in its first
    // IDLE cycle.
    assign a_ready = (state_q == IDLE) && grant_a;
    assign b_ready = (state_q == IDLE) && grant_b;

    // Result handshake completes only for the current owner.
    assign owner_done = (owner_q == OWN_A) ? a_rsp_ready : b_rsp_ready;

    // Control FSM with registered datapath and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= OWN_A;
            last_grant_q  <= OWN_B;
            x_q           <= '0;
            y_q           <= '0;
            sum_q         <= '0;
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (a_ready) begin
                        x_q          <= a_x;
                        y_q          <= a_y;
                        owner_q      <= OWN_A;
                        last_grant_q <= OWN_A;
                        busy_q       <= 1'b1;
                        state_q      <= EXEC;
                    end else if (b_ready) begin
                        x_q          <= b_x;
                        y_q          <= b_y;
                        owner_q      <= OWN_B;
                        last_grant_q <= OWN_B;
                        busy_q       <= 1'b1;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    sum_q   <= add_sum;
                    state_q <= RESP;
                    if (owner_q == OWN_A) begin
                        a_rsp_valid_q <= 1'b1;
                    end else begin
                        b_rsp_valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    // sum_q is left untouched so it stays stable under backpressure.
                    if (owner_done) begin
                        a_rsp_valid_q <= 1'b0;
                        b_rsp_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign a_rsp_valid = a_rsp_valid_q;
    assign b_rsp_valid = b_rsp_valid_q;
    assign sum         = sum_q;
    assign busy        = busy_q;

endmodule
